// File: rtl/subpel_pkg.sv
// Shared definitions for the sub-pixel interpolation path: pixel/window sizes,
// flat window buffer layout and the reference loader state encoding.
package subpel_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned BLK      = 15;
  localparam int unsigned IN_BUF_W = BLK * BLK * PIX_W;
  localparam int unsigned OFF_W    = $clog2(IN_BUF_W);
  localparam int unsigned IDX_W    = $clog2(BLK);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    VALID
  } state_e;

  // Bit offset of pixel (row, col) inside the flat window buffer.
  function automatic logic [OFF_W-1:0] pix_off(input logic [IDX_W-1:0] row,
                                               input logic [IDX_W-1:0] col);
    return OFF_W'((32'(row) * BLK + 32'(col)) * PIX_W);
  endfunction

endpackage

// File: rtl/ref_coord_clamp.sv
// Signed base + unsigned offset, clamped to [0, LIMIT-1] so reads past the
// frame edge replicate the edge pixel.
module ref_coord_clamp #(
  parameter int unsigned COORD_W = 9,
  parameter int unsigned OFS_W   = 4,
  parameter int unsigned LIMIT   = 64,
  parameter int unsigned OUT_W   = 6
) (
  input  logic signed [COORD_W-1:0] base,
  input  logic        [OFS_W-1:0]   ofs,
  output logic        [OUT_W-1:0]   coord_c
);

  localparam logic signed [COORD_W:0] MAX = (COORD_W+1)'(LIMIT - 1);

  logic signed [COORD_W:0] sum;

  // One extra bit of headroom keeps the sum from wrapping.
  always_comb begin
    sum = $signed({base[COORD_W-1], base}) + $signed({1'b0, COORD_W'(ofs)});
    if (sum[COORD_W]) begin
      coord_c = '0;
    end else if (sum > MAX) begin
      coord_c = OUT_W'(LIMIT - 1);
    end else begin
      coord_c = sum[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ref_block_loader.sv
// Fetches a 15x15 edge-padded reference window from frame memory, one pixel
// per cycle, and presents it packed for the interpolator with valid/ready.
module ref_block_loader
  import subpel_pkg::*;
#(
  parameter int unsigned FRAME_W = 64,
  parameter int unsigned FRAME_H = 64,
  parameter int unsigned COORD_W = 9,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] base_x,
  input  logic signed [COORD_W-1:0] base_y,
  output logic                      mem_rd_en,
  output logic        [ADDR_W-1:0]  mem_addr,
  input  logic        [PIX_W-1:0]   mem_rd_data,
  output logic        [IN_BUF_W-1:0] out_buffer,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int unsigned XW = $clog2(FRAME_W);
  localparam int unsigned YW = $clog2(FRAME_H);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BLK - 1);

  state_e state_q, state_d;

  logic signed [COORD_W-1:0] bx_q, by_q, bx_src, by_src;
  logic [IDX_W-1:0] row_q, col_q, row_d, col_d;
  logic [IDX_W-1:0] cap_row_q, cap_col_q;
  logic             cap_vld_q;
  logic             rd_en_d;
  logic [XW-1:0]    x_c;
  logic [YW-1:0]    y_c;
  logic [ADDR_W-1:0] addr_d;

  ref_coord_clamp #(
    .COORD_W(COORD_W), .OFS_W(IDX_W), .LIMIT(FRAME_W), .OUT_W(XW)
  ) u_clamp_x (
    .base(bx_src), .ofs(col_d), .coord_c(x_c)
  );

  ref_coord_clamp #(
    .COORD_W(COORD_W), .OFS_W(IDX_W), .LIMIT(FRAME_H), .OUT_W(YW)
  ) u_clamp_y (
    .base(by_src), .ofs(row_d), .coord_c(y_c)
  );

  assign addr_d = (ADDR_W'(y_c) << XW) + ADDR_W'(x_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // row/col track the read presented on the bus; *_d is the next cycle's read.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    rd_en_d = 1'b0;
    bx_src  = bx_q;
    by_src  = by_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          bx_src  = base_x;
          by_src  = base_y;
        end
      end
      FETCH: begin
        if (row_q == LAST && col_q == LAST) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
          if (col_q == LAST) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      DRAIN: state_d = VALID;
      VALID: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q       <= '0;
      by_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
      out_buffer <= '0;
    end else begin
      bx_q      <= bx_src;
      by_q      <= by_src;
      row_q     <= row_d;
      col_q     <= col_d;
      mem_rd_en <= rd_en_d;
      if (rd_en_d) begin
        mem_addr <= addr_d;
      end
      out_valid <= (state_d == VALID);
      busy      <= (state_d != IDLE);
      // Slot tag travels one cycle behind the read to meet the returning data.
      cap_vld_q <= mem_rd_en;
      cap_row_q <= row_q;
      cap_col_q <= col_q;
      if (cap_vld_q && (state_q == FETCH || state_q == DRAIN)) begin
        out_buffer[pix_off(cap_row_q, cap_col_q) +: PIX_W] <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ref_block_loader.sv
// Randomized and directed bench for ref_block_loader against a timing/window
// reference model, with a 64x64 frame memory of 1-cycle read latency.
module tb_ref_block_loader;
  import subpel_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic signed [8:0]     base_x, base_y;
  logic                  mem_rd_en;
  logic [11:0]           mem_addr;
  logic [7:0]            mem_rd_data;
  logic [IN_BUF_W-1:0]   out_buffer;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ref_block_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_x(base_x), .base_y(base_y),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_buffer(out_buffer), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory: pix(x,y) = (x + 16*y) & 0xFF; junk when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'((32'(mem_addr[5:0]) + 16 * 32'(mem_addr[11:6])) & 255);
    else           mem_rd_data <= 8'($urandom);
  end

  function automatic int clampi(input int v, input int lim);
    return (v < 0) ? 0 : ((v > lim - 1) ? lim - 1 : v);
  endfunction

  function automatic int ref_addr(input int bx, input int by, input int k);
    return clampi(by + k / 15, 64) * 64 + clampi(bx + k % 15, 64);
  endfunction

  function automatic int ref_pix(input int bx, input int by, input int j, input int i);
    return (clampi(bx + i, 64) + 16 * clampi(by + j, 64)) & 255;
  endfunction

  function automatic int dut_pix(input int j, input int i);
    int off;
    off = (j * 15 + i) * 8;
    return int'(out_buffer[off +: 8]);
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_window(input int bx, input int by);
    int bad;
    bad = -1;
    for (int k = 0; k < 225; k++)
      if (bad < 0 && dut_pix(k / 15, k % 15) != ref_pix(bx, by, k / 15, k % 15)) bad = k;
    if (bad < 0) bad = 0;
    chk($sformatf("window pixel(%0d,%0d)", bad / 15, bad % 15),
        dut_pix(bad / 15, bad % 15), ref_pix(bx, by, bad / 15, bad % 15));
  endtask

  // Reference model: cycles elapsed since an accepted start decide every output.
  bit m_known = 0, m_busy = 0, m_clean = 0;
  int m_n = 0, m_bx = 0, m_by = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("mem_rd_en", int'(mem_rd_en), int'(m_busy && m_n >= 1 && m_n <= 225));
        if (m_busy && m_n >= 1 && m_n <= 225)
          chk("mem_addr", int'(mem_addr), ref_addr(m_bx, m_by, m_n - 1));
        chk("out_valid", int'(out_valid), int'(m_busy && m_n >= 227));
        chk("busy", int'(busy), int'(m_busy));
        if (m_busy && m_n >= 227) chk_window(m_bx, m_by);
        if (m_clean) chk("buffer_clear", int'(out_buffer != '0), 0);
      end
      if (rst) begin
        m_known = 1; m_busy = 0; m_clean = 1; m_n = 0;
      end else if (m_known) begin
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_n = 1; m_clean = 0;
            m_bx = int'(base_x); m_by = int'(base_y);
          end
        end else if (m_n >= 227 && out_ready) begin
          m_busy = 0;
        end else begin
          m_n++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a fetch, checks first address/read count/latency, stops at out_valid.
  task automatic fetch(input int bx, input int by, input int exp_addr0);
    int c, lat, reads;
    base_x = 9'(bx); base_y = 9'(by); start = 1'b1;
    c = cyc; lat = -1; reads = 0;
    step();
    start = 1'b0;
    chk("first_addr", int'(mem_addr), exp_addr0);
    for (int t = 0; t < 400; t++) begin
      if (out_valid) begin
        lat = cyc - c;
        break;
      end
      if (mem_rd_en) reads++;
      step();
    end
    chk("latency", lat, 227);
    chk("read_count", reads, 225);
  endtask

  logic [IN_BUF_W-1:0] snap;

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_x = '0; base_y = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_mem_rd_en", int'(mem_rd_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);

    // Interior window
    out_ready = 1'b1;
    fetch(3, 3, 195);
    chk("int_p00", dut_pix(0, 0), 'h33);
    chk("int_p12", dut_pix(1, 2), 'h45);
    chk("int_p1414", dut_pix(14, 14), 'h21);
    step();
    chk("int_valid_one_cycle", int'(out_valid), 0);
    chk("int_busy_after_hs", int'(busy), 0);
    step();

    // Top-left padding
    fetch(-3, -3, 0);
    chk("tl_p00", dut_pix(0, 0), 'h00);
    chk("tl_p25", dut_pix(2, 5), 'h02);
    chk("tl_p43", dut_pix(4, 3), 'h10);
    chk("tl_p1414", dut_pix(14, 14), 'hBB);
    step(); step();

    // Bottom-right padding
    fetch(55, 55, 3575);
    chk("br_p1414", dut_pix(14, 14), 'h2F);
    chk("br_p08", dut_pix(0, 8), 'hAF);
    step(); step();

    // Backpressure with ignored starts, including on the handshake cycle
    out_ready = 1'b0;
    fetch(10, 20, 20 * 64 + 10);
    snap = out_buffer;
    for (int t = 0; t < 20; t++) begin
      start = t[0]; base_x = 9'(t); base_y = 9'(-t);
      step();
      chk("bp_stable", int'(out_buffer == snap), 1);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_no_read", int'(mem_rd_en), 0);
    end
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("bp_idle", int'(busy), 0);
    chk("bp_start_ignored", int'(mem_rd_en), 0);
    step();

    // Reset in the middle of a fetch
    base_x = 9'(3); base_y = 9'(3); start = 1'b1;
    begin
      int c;
      c = cyc;
      step();
      start = 1'b0;
      while (cyc < c + 100) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rd_en", int'(mem_rd_en), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_buffer", int'(out_buffer != '0), 0);
    step();
    fetch(3, 3, 195);
    chk("rerun_p00", dut_pix(0, 0), 'h33);
    chk("rerun_p12", dut_pix(1, 2), 'h45);
    chk("rerun_p1414", dut_pix(14, 14), 'h21);
    step();

    // Random traffic; the model process does the checking
    for (int t = 0; t < 5000; t++) begin
      rst       = ($urandom % 1800 == 0);
      start     = ($urandom % 6 == 0);
      out_ready = ($urandom % 3 == 0);
      base_x    = 9'(int'($urandom_range(0, 110)) - 30);
      base_y    = 9'(int'($urandom_range(0, 110)) - 30);
      step();
    end
    rst = 1'b0; start = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
